// File: rtl/input_conditioner_if.sv
// Pin-side bundle between the board inputs and the input conditioner:
// raw pin levels in, debounced level / press / release / toggle out.
interface input_conditioner_if #(
    parameter int Channels = 5
);
    logic [Channels-1:0] i_raw;
    logic [Channels-1:0] o_level;
    logic [Channels-1:0] o_press;
    logic [Channels-1:0] o_release;
    logic [Channels-1:0] o_toggle;

    modport master (
        output i_raw,
        input  o_level,
        input  o_press,
        input  o_release,
        input  o_toggle
    );

    modport slave (
        input  i_raw,
        output o_level,
        output o_press,
        output o_release,
        output o_toggle
    );
endinterface

// File: rtl/input_conditioner.sv
// Per-channel 2-FF synchroniser, 4-state debounce FSM and registered
// level / press / release / toggle outputs for board buttons and switches.
module input_conditioner #(
    parameter int                  Channels       = 5,
    parameter int                  DebounceCycles = 500000,
    parameter logic [Channels-1:0] InvertMask     = '0
) (
    input  logic                i_clock_50mhz,
    input  logic                i_reset,
    input_conditioner_if.slave  bus
);

    localparam int              CntW   = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHECK_HI  = 2'd1,
        STABLE_HI = 2'd2,
        CHECK_LO  = 2'd3
    } state_e;

    logic [Channels-1:0] level_vec;
    logic [Channels-1:0] press_vec;
    logic [Channels-1:0] release_vec;
    logic [Channels-1:0] toggle_vec;

    genvar gi;
    generate
        for (gi = 0; gi < Channels; gi++) begin : g_ch
            logic            sync1_q;
            logic            sync2_q;
            logic            s_act;
            state_e          state_q;
            state_e          state_d;
            logic [CntW-1:0] cnt_q;
            logic [CntW-1:0] cnt_d;
            logic            level_q;
            logic            level_d;
            logic            press_q;
            logic            press_d;
            logic            release_q;
            logic            release_d;
            logic            toggle_q;
            logic            toggle_d;

            // Reset loads the inverted-inactive value so s_act reads 0 straight out of reset.
            always_ff @(posedge i_clock_50mhz or negedge i_reset) begin
                if (!i_reset) begin
                    sync1_q <= InvertMask[gi];
                    sync2_q <= InvertMask[gi];
                end else begin
                    sync1_q <= bus.i_raw[gi];
                    sync2_q <= sync1_q;
                end
            end

            assign s_act = sync2_q ^ InvertMask[gi];

            always_comb begin
                state_d   = state_q;
                cnt_d     = cnt_q;
                level_d   = level_q;
                press_d   = 1'b0;
                release_d = 1'b0;
                toggle_d  = toggle_q;
                case (state_q)
                    STABLE_LO: begin
                        cnt_d = '0;
                        if (s_act) begin
                            state_d = CHECK_HI;
                            cnt_d   = CntOne;
                        end
                    end
                    CHECK_HI: begin
                        if (!s_act) begin
                            state_d = STABLE_LO;
                            cnt_d   = '0;
                        end else if (cnt_q == CntMax) begin
                            state_d  = STABLE_HI;
                            cnt_d    = '0;
                            level_d  = 1'b1;
                            press_d  = 1'b1;
                            toggle_d = ~toggle_q;
                        end else begin
                            cnt_d = cnt_q + CntOne;
                        end
                    end
                    STABLE_HI: begin
                        cnt_d = '0;
                        if (!s_act) begin
                            state_d = CHECK_LO;
                            cnt_d   = CntOne;
                        end
                    end
                    CHECK_LO: begin
                        if (s_act) begin
                            state_d = STABLE_HI;
                            cnt_d   = '0;
                        end else if (cnt_q == CntMax) begin
                            state_d   = STABLE_LO;
                            cnt_d     = '0;
                            level_d   = 1'b0;
                            release_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CntOne;
                        end
                    end
                    default: begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                    end
                endcase
            end

            always_ff @(posedge i_clock_50mhz or negedge i_reset) begin
                if (!i_reset) begin
                    state_q   <= STABLE_LO;
                    cnt_q     <= '0;
                    level_q   <= 1'b0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                    toggle_q  <= 1'b0;
                end else begin
                    state_q   <= state_d;
                    cnt_q     <= cnt_d;
                    level_q   <= level_d;
                    press_q   <= press_d;
                    release_q <= release_d;
                    toggle_q  <= toggle_d;
                end
            end

            assign level_vec[gi]   = level_q;
            assign press_vec[gi]   = press_q;
            assign release_vec[gi] = release_q;
            assign toggle_vec[gi]  = toggle_q;
        end
    endgenerate

    assign bus.o_level   = level_vec;
    assign bus.o_press   = press_vec;
    assign bus.o_release = release_vec;
    assign bus.o_toggle  = toggle_vec;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench: stimulus pushes expected press/release events into a queue,
// a negedge monitor pops them on their due cycle and checks all outputs.
module tb_input_conditioner;

    localparam int Ch = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    input_conditioner_if #(.Channels(Ch)) ifa ();
    input_conditioner_if #(.Channels(Ch)) ifb ();

    input_conditioner #(
        .Channels(Ch), .DebounceCycles(4), .InvertMask(5'b00001)
    ) dut_a (
        .i_clock_50mhz(clk),
        .i_reset      (rst_n),
        .bus          (ifa.slave)
    );

    input_conditioner #(
        .Channels(Ch), .DebounceCycles(1), .InvertMask(5'b00001)
    ) dut_b (
        .i_clock_50mhz(clk),
        .i_reset      (rst_n),
        .bus          (ifb.slave)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       due;
        int       d;
        logic [4:0] press;
        logic [4:0] rel;
    } ev_t;

    ev_t        exp_q[$];
    logic [4:0] lvl_m[2];
    logic [4:0] tgl_m[2];
    logic [4:0] ep[2];
    logic [4:0] er[2];

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic push_ev(input int d, input int lat, input logic [4:0] p, input logic [4:0] r);
        ev_t e;
        e.due   = cyc + lat;
        e.d     = d;
        e.press = p;
        e.rel   = r;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            ep[d] = '0;
            er[d] = '0;
        end
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                lvl_m[d] = '0;
                tgl_m[d] = '0;
            end
        end else begin
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].due == cyc) begin
                    ep[exp_q[i].d] = ep[exp_q[i].d] | exp_q[i].press;
                    er[exp_q[i].d] = er[exp_q[i].d] | exp_q[i].rel;
                    $display("event cyc=%0d dut=%0d press=%b release=%b",
                             cyc, exp_q[i].d, exp_q[i].press, exp_q[i].rel);
                    exp_q.delete(i);
                end
            end
            for (int d = 0; d < 2; d++) begin
                lvl_m[d] = (lvl_m[d] | ep[d]) & ~er[d];
                tgl_m[d] = tgl_m[d] ^ ep[d];
            end
        end
        chk("a_level",   ifa.o_level,   lvl_m[0]);
        chk("a_press",   ifa.o_press,   ep[0]);
        chk("a_release", ifa.o_release, er[0]);
        chk("a_toggle",  ifa.o_toggle,  tgl_m[0]);
        chk("b_level",   ifb.o_level,   lvl_m[1]);
        chk("b_press",   ifb.o_press,   ep[1]);
        chk("b_release", ifb.o_release, er[1]);
        chk("b_toggle",  ifb.o_toggle,  tgl_m[1]);
    end

    initial begin
        ifa.i_raw = 5'($urandom);
        ifb.i_raw = 5'($urandom);

        // Reset held with random pins: monitor expects all-zero outputs.
        for (int i = 0; i < 8; i++) begin
            step(1);
            ifa.i_raw = 5'($urandom);
            ifb.i_raw = 5'($urandom);
        end
        step(1);
        ifa.i_raw = 5'b00001;
        ifb.i_raw = 5'b00001;
        step(2);
        rst_n = 1'b1;
        step(10);

        // Clean press and release on ch1.
        ifa.i_raw[1] = 1'b1;
        push_ev(0, 7, 5'b00010, 5'b00000);
        step(12);
        ifa.i_raw[1] = 1'b0;
        push_ev(0, 7, 5'b00000, 5'b00010);
        step(12);

        // Bounce 1,0,1,1,0 on ch2, then held high.
        ifa.i_raw[2] = 1'b1; step(1);
        ifa.i_raw[2] = 1'b0; step(1);
        ifa.i_raw[2] = 1'b1; step(1);
        step(1);
        ifa.i_raw[2] = 1'b0; step(1);
        ifa.i_raw[2] = 1'b1;
        push_ev(0, 7, 5'b00100, 5'b00000);
        step(12);
        ifa.i_raw[2] = 1'b0;
        push_ev(0, 7, 5'b00000, 5'b00100);
        step(12);

        // Active-low ch0: two full press/release cycles.
        for (int k = 0; k < 2; k++) begin
            ifa.i_raw[0] = 1'b0;
            push_ev(0, 7, 5'b00001, 5'b00000);
            step(12);
            ifa.i_raw[0] = 1'b1;
            push_ev(0, 7, 5'b00000, 5'b00001);
            step(12);
        end

        // ch3 and ch4 together; ch4 glitches low for one cycle mid-check.
        ifa.i_raw[3] = 1'b1;
        ifa.i_raw[4] = 1'b1;
        push_ev(0, 7, 5'b01000, 5'b00000);
        step(2);
        ifa.i_raw[4] = 1'b0;
        step(1);
        ifa.i_raw[4] = 1'b1;
        push_ev(0, 7, 5'b10000, 5'b00000);
        step(12);
        ifa.i_raw[3] = 1'b0;
        ifa.i_raw[4] = 1'b0;
        push_ev(0, 7, 5'b00000, 5'b11000);
        step(12);

        // Reset while ch1 sits in CHECK_HI at count 3; toggles are nonzero beforehand.
        ifa.i_raw[1] = 1'b1;
        step(5);
        rst_n = 1'b0;
        #1;
        chk("a_rst_level",  ifa.o_level,  5'b00000);
        chk("a_rst_press",  ifa.o_press,  5'b00000);
        chk("a_rst_toggle", ifa.o_toggle, 5'b00000);
        step(3);
        rst_n = 1'b1;
        push_ev(0, 7, 5'b00010, 5'b00000);
        step(12);

        // Same on the single-cycle debounce instance; dut_a ch1 still held.
        ifb.i_raw[1] = 1'b1;
        step(3);
        rst_n = 1'b0;
        #1;
        chk("a_rst2_level", ifa.o_level, 5'b00000);
        chk("b_rst_level",  ifb.o_level, 5'b00000);
        chk("b_rst_press",  ifb.o_press, 5'b00000);
        step(2);
        rst_n = 1'b1;
        push_ev(0, 7, 5'b00010, 5'b00000);
        push_ev(1, 4, 5'b00010, 5'b00000);
        step(12);
        ifa.i_raw[1] = 1'b0;
        ifb.i_raw[1] = 1'b0;
        push_ev(0, 7, 5'b00000, 5'b00010);
        push_ev(1, 4, 5'b00000, 5'b00010);
        step(12);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL pending_events observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
